// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the maximal-length tap table for widths 3..32.
package lfsr_pkg;

    localparam int LFSR_DEFAULT_WIDTH = 15;
    localparam int LFSR_DEFAULT_SEED  = 1;

    // Bit i set means state bit i feeds the feedback XOR (tap n -> bit n-1).
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_15bit.sv
// Free-running Fibonacci LFSR, shifting toward the MSB with feedback into bit 0.
// Define LFSR_ZERO_GUARD_EN to reload SEED from an all-zero state.
module lfsr_15bit
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             nreset,
    output logic [WIDTH-1:0] out
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "lfsr_15bit: WIDTH %0d outside 3..32", WIDTH);
    end

    if (TAPS == '0) begin : g_bad_taps
        $fatal(1, "lfsr_15bit: TAPS must be non-zero");
    end

`ifdef LFSR_ZERO_GUARD_EN
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
`else
    localparam logic [WIDTH-1:0] SEED_EFF = SEED;

    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "lfsr_15bit: SEED must be non-zero");
    end
`endif

    logic [WIDTH-1:0] state;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= SEED_EFF;
`ifdef LFSR_ZERO_GUARD_EN
        end else if (state == '0) begin
            // all-zero is a lock-up state; recover in one cycle
            state <= SEED_EFF;
`endif
        end else begin
            state <= {state[WIDTH-2:0], ^(state & TAPS)};
        end
    end

    assign out = state;

endmodule

// File: tb/tb_lfsr_15bit.sv
// Randomized self-checking bench for lfsr_15bit (default 15-bit and a 4-bit variant).
module tb_lfsr_15bit;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic [14:0] out;
    logic [3:0]  out4;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m15, m4;

    lfsr_15bit dut (.clk(clk), .nreset(nreset), .out(out));

    lfsr_15bit #(.WIDTH(4), .SEED(4'h1), .TAPS(4'hC)) dut4 (.clk(clk), .nreset(nreset), .out(out4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: shift left within w bits, insert parity of the tapped bits.
    function automatic logic [31:0] ref_next(input logic [31:0] s, input int w, input logic [31:0] taps);
        logic [31:0] mask;
        logic [31:0] par;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        par  = 32'($countones(s & taps)) % 32'd2;
        return ((s << 1) & mask) | par;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        m15 = ref_next(m15, 15, 32'h6000);
        m4  = ref_next(m4, 4, 32'hC);
        chk("model15", 32'(out), m15);
        chk("model4", 32'(out4), m4);
    endtask

    // Asynchronous reset pulse, starting away from any clock edge.
    task automatic async_reset(input string tag);
        nreset = 1'b0;
        #1;
        chk(tag, 32'(out), 32'h1);
        chk({tag, "_w4"}, 32'(out4), 32'h1);
        m15 = 32'h1;
        m4  = 32'h1;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    logic [31:0] walk_exp [16];
    bit          seen [32768];
    int          dup, zero_seen, early4;
    int          n;

    initial begin
        for (int i = 0; i < 13; i++) walk_exp[i] = 32'h1 << (i + 1);
        walk_exp[13] = 32'h4001;
        walk_exp[14] = 32'h0003;
        walk_exp[15] = 32'h0006;

        // reset mid-cycle while the clock runs
        #2;
        async_reset("reset");

        // walk, including the 4-bit variant's first steps and period
        early4 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("walk", 32'(out), walk_exp[i]);
            if (i < 14 && out4 == 4'h1) early4 = 1;
            if (i == 0) chk("w4_e1", 32'(out4), 32'h2);
            if (i == 1) chk("w4_e2", 32'(out4), 32'h4);
            if (i == 2) chk("w4_e3", 32'(out4), 32'h9);
            if (i == 14) chk("w4_period", 32'(out4), 32'h1);
        end
        chk("w4_no_early_wrap", 32'(early4), 32'h0);

        // full period
        @(posedge clk);
        #3;
        async_reset("reset_period");
        for (int v = 0; v < 32768; v++) seen[v] = 1'b0;
        seen[1] = 1'b1;
        dup = 0;
        zero_seen = 0;
        for (int i = 1; i <= 32767; i++) begin
            step();
            if (out == 15'h0) zero_seen = 1;
            if (i < 32767) begin
                if (seen[out]) dup = 1;
                seen[out] = 1'b1;
            end
        end
        chk("period_return", 32'(out), 32'h1);
        chk("no_early_repeat", 32'(dup), 32'h0);
        chk("never_zero", 32'(zero_seen), 32'h0);

        // reset after 100 edges, then the sequence restarts
        repeat (100) step();
        #2;
        async_reset("reset_midrun");
        step();
        chk("restart", 32'(out), 32'h2);

        // randomized run lengths with asynchronous resets at random phases
        for (int k = 0; k < 20; k++) begin
            n = int'($urandom_range(1, 200));
            repeat (n) step();
            #($urandom_range(1, 3));
            async_reset("reset_rand");
        end

        // forced all-zero state
        step();
        @(negedge clk);
        force dut.state = 15'h0;
        #1;
        release dut.state;
        chk("zero_forced", 32'(out), 32'h0);
        @(posedge clk);
        #1;
`ifdef LFSR_ZERO_GUARD_EN
        chk("zero_recover", 32'(out), 32'h1);
`else
        chk("zero_stuck", 32'(out), 32'h0);
`endif
        @(posedge clk);
        #1;
`ifdef LFSR_ZERO_GUARD_EN
        chk("zero_resume", 32'(out), 32'h2);
`else
        chk("zero_stuck2", 32'(out), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
